vga_sync_rx: RTL
================

// Module: vga_sync_rx
// PURPOSE
//  Receive side of the 640x480@60 VGA timing link: samples incoming hsync/vsync,
//  recovers pixel x/y and an active-video flag, and measures line/frame length.
//  Asserts lock once timing matches the expected mode for several frames.
//  Used for loopback checking of the VGA generator and for capture-side alignment.
// PARAMETERS
//  HPIXELS     800  expected pixel clocks per line
//  VLINES      521  expected lines per frame
//  HBP         144  h_cnt value bounding active video on the left (exclusive)
//  HFP         784  h_cnt value bounding active video on the right (exclusive)
//  VBP         31   v_cnt value bounding active video at the top (exclusive)
//  VFP         511  v_cnt value bounding active video at the bottom (exclusive)
//  LOCK_FRAMES 2    consecutive matching frames required for lock (1..15)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  pix_en      in   1   pixel strobe, one clk wide (clk/4 in the system)
//  hsync_in    in   1   hsync, low during the sync pulse, asynchronous to clk
//  vsync_in    in   1   vsync, low during the sync pulse, asynchronous to clk
//  x_pos       out  10  h_cnt-HBP while active, else 0
//  y_pos       out  10  v_cnt-VBP while active, else 0
//  active      out  1   HBP<h_cnt<HFP && VBP<v_cnt<VFP
//  locked      out  1   FSM in LOCKED
//  line_len    out  10  last measured line length in pixel strobes
//  frame_lines out  10  last measured frame length in lines
//  err         out  1   one-clk pulse on a timing mismatch while LOCKED
// BEHAVIOUR
//  - Reset (low) clears every register, every output = 0, FSM = SEARCH; takes effect at any time,
//    including mid-frame. Measurements restart from scratch after reset release.
//  - hsync_in/vsync_in pass through a 2-FF synchronizer on clk. All other logic updates only
//    on cycles with pix_en=1. hs_prev/vs_prev hold the synchronized values from the previous
//    pix_en.
//  - hfall = pix_en & hs_prev & ~hs_sync. On hfall: line_len <= h_cnt+1; h_cnt <= 0.
//    Otherwise h_cnt increments and saturates at 1023. Saturation is a timeout.
//  - At hfall, a frame start is vs_sync=0 && vs_at_last_line=1, where vs_at_last_line is the
//    vs_sync value captured at the previous hfall.
//    On a frame start: frame_lines <= v_cnt+1; v_cnt <= 0.
//    On any other hfall: v_cnt increments and saturates at 1023.
//  - The hfall rule takes priority over saturation when both occur in the same pix_en.
//  - Recovered counters lag the transmitter by 2-3 clk (synchronizer); pixel-level alignment is
//    otherwise exact.
//  - x_pos, y_pos and active are combinational from h_cnt/v_cnt; widths are 10 bits,
//    subtraction wraps and is masked by active.
//  - FSM:
//      SEARCH -> CHECK on the first frame start; match_cnt <= 0.
//      CHECK: at each later frame start, if line_len==HPIXELS && frame_lines==VLINES then
//        match_cnt++; on reaching LOCK_FRAMES -> LOCKED. Any mismatch -> match_cnt <= 0
//        and stay in CHECK.
//      LOCKED: any of the events below -> err=1 for one clk, FSM -> SEARCH, locked deasserts
//      on the same edge:
//        line_len!=HPIXELS at an hfall
//        frame_lines!=VLINES at a frame start
//        h_cnt saturation (hsync lost)
//      Timeout in SEARCH or CHECK -> SEARCH, no err pulse.
//  - Measured values compare on the pix_en after they are latched, so a mismatch is flagged
//    1 pix_en after the offending edge.
// CONFIGURATION
//  VGA_RX_STATS_EN defined: adds two outputs. Neither counter wraps.
//    frame_cnt  out 16  frame starts seen while LOCKED, saturating
//    err_cnt    out 8   err pulses, saturating
//    Both clear only on reset.
//  VGA_RX_STATS_EN undefined: these ports and counters do not exist; all other behaviour is
//    identical.
// TESTING
//  1 Reset release, drive 800x521 timing (hsync low for x<96, vsync low for y<2), pix_en=clk/4
//    -> locked=1 at the frame start after 3 full frames; line_len=800, frame_lines=521.
//  2 Locked, check active-video corners -> active first at h_cnt=145,v_cnt=32 with
//    x_pos=1,y_pos=1; last at h_cnt=783,v_cnt=510; x_pos/y_pos=0 outside.
//  3 Locked, shorten one line to 799 pixels -> single err pulse, locked=0, FSM back to CHECK
//    after next frame start, relocks after 2 good frames.
//  4 Locked, hold hsync_in high -> h_cnt saturates at 1023, err pulses once, locked=0;
//    no further err pulses.
//  5 Drive 800x520 frames -> never locks, err stays 0, frame_lines=520.
//  6 Assert reset mid-frame while locked -> all outputs 0 immediately; after release
//    relock per scenario 1. With VGA_RX_STATS_EN: err_cnt=1 after scenario 3, frame_cnt
//    stops at 65535.

Source files
------------

// File: rtl/vga_sync_rx_if.sv
// Signal bundle between a VGA timing source and the vga_sync_rx receiver.
// The frame_cnt/err_cnt statistics signals exist only when VGA_RX_STATS_EN is defined.
interface vga_sync_rx_if;
    logic        pix_en;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        active;
    logic        locked;
    logic [9:0]  line_len;
    logic [9:0]  frame_lines;
    logic        err;
`ifdef VGA_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    modport master (
        output pix_en,
        output hsync_in,
        output vsync_in,
        input  x_pos,
        input  y_pos,
        input  active,
        input  locked,
        input  line_len,
        input  frame_lines,
        input  err
`ifdef VGA_RX_STATS_EN
        ,
        input  frame_cnt,
        input  err_cnt
`endif
    );

    modport slave (
        input  pix_en,
        input  hsync_in,
        input  vsync_in,
        output x_pos,
        output y_pos,
        output active,
        output locked,
        output line_len,
        output frame_lines,
        output err
`ifdef VGA_RX_STATS_EN
        ,
        output frame_cnt,
        output err_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: pixel position, active flag, line/frame measurement, lock FSM.
// Define VGA_RX_STATS_EN to add saturating frame_cnt/err_cnt statistics outputs.
module vga_sync_rx #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    vga_sync_rx_if.slave io_vga
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] CNT_PRE = 10'd1022;
    localparam logic [9:0] P_HPIX  = 10'(HPIXELS);
    localparam logic [9:0] P_VLIN  = 10'(VLINES);
    localparam logic [9:0] P_HBP   = 10'(HBP);
    localparam logic [9:0] P_HFP   = 10'(HFP);
    localparam logic [9:0] P_VBP   = 10'(VBP);
    localparam logic [9:0] P_VFP   = 10'(VFP);
    localparam logic [3:0] P_LOCK  = 4'(LOCK_FRAMES);

    logic       r_hs_meta;
    logic       r_hs_sync;
    logic       r_vs_meta;
    logic       r_vs_sync;
    logic       r_hs_prev;
    logic       r_vs_last;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [9:0] r_line_len;
    logic [9:0] r_frame_lines;
    logic       r_hchk;
    logic       r_fchk;
    state_t     r_state;
    logic [3:0] r_match_cnt;
    logic       r_err;

    logic       w_pix_en;
    logic       w_hfall;
    logic       w_fstart;
    logic       w_timeout;
    logic       w_line_ok;
    logic       w_frame_ok;
    logic       w_active;
    logic [3:0] w_match_inc;
    state_t     w_state_nxt;
    logic [3:0] w_match_nxt;
    logic       w_err_nxt;

    assign w_pix_en    = io_vga.pix_en;
    assign w_hfall     = w_pix_en & r_hs_prev & ~r_hs_sync;
    assign w_fstart    = w_hfall & ~r_vs_sync & r_vs_last;
    assign w_timeout   = w_pix_en & ~w_hfall & (r_h_cnt == CNT_PRE);
    assign w_line_ok   = (r_line_len == P_HPIX);
    assign w_frame_ok  = (r_frame_lines == P_VLIN);
    assign w_match_inc = r_match_cnt + 4'd1;

    // Both sync inputs are asynchronous to clk, so they get a plain two-flop synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs_meta <= 1'b0;
            r_hs_sync <= 1'b0;
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
        end else begin
            r_hs_meta <= io_vga.hsync_in;
            r_hs_sync <= r_hs_meta;
            r_vs_meta <= io_vga.vsync_in;
            r_vs_sync <= r_vs_meta;
        end
    end

    // Counters and measurements; an hsync fall wins over saturation, and r_hchk/r_fchk
    // delay the compare of freshly latched lengths by one pixel strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs_prev     <= 1'b0;
            r_vs_last     <= 1'b0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_line_len    <= 10'd0;
            r_frame_lines <= 10'd0;
            r_hchk        <= 1'b0;
            r_fchk        <= 1'b0;
        end else if (w_pix_en) begin
            r_hs_prev <= r_hs_sync;
            r_hchk    <= w_hfall;
            r_fchk    <= w_fstart;
            if (w_hfall) begin
                r_line_len <= r_h_cnt + 10'd1;
                r_h_cnt    <= 10'd0;
                r_vs_last  <= r_vs_sync;
                if (w_fstart) begin
                    r_frame_lines <= r_v_cnt + 10'd1;
                    r_v_cnt       <= 10'd0;
                end else if (r_v_cnt != CNT_MAX) begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else if (r_h_cnt != CNT_MAX) begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_match_cnt <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Lock FSM: a hsync timeout outside LOCKED silently restarts the search.
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        w_err_nxt   = 1'b0;
        if (w_pix_en) begin
            unique case (r_state)
                SEARCH: begin
                    if (!w_timeout && r_fchk) begin
                        w_state_nxt = CHECK;
                        w_match_nxt = 4'd0;
                    end
                end
                CHECK: begin
                    if (w_timeout) begin
                        w_state_nxt = SEARCH;
                        w_match_nxt = 4'd0;
                    end else if (r_fchk) begin
                        if (w_line_ok && w_frame_ok) begin
                            w_match_nxt = w_match_inc;
                            if (w_match_inc == P_LOCK) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_match_nxt = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_timeout || (r_hchk && !w_line_ok) || (r_fchk && !w_frame_ok)) begin
                        w_state_nxt = SEARCH;
                        w_match_nxt = 4'd0;
                        w_err_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_match_nxt = 4'd0;
                end
            endcase
        end
    end

    assign w_active = (r_h_cnt > P_HBP) && (r_h_cnt < P_HFP) &&
                      (r_v_cnt > P_VBP) && (r_v_cnt < P_VFP);

    assign io_vga.active      = w_active;
    assign io_vga.x_pos       = w_active ? (r_h_cnt - P_HBP) : 10'd0;
    assign io_vga.y_pos       = w_active ? (r_v_cnt - P_VBP) : 10'd0;
    assign io_vga.locked      = (r_state == LOCKED);
    assign io_vga.line_len    = r_line_len;
    assign io_vga.frame_lines = r_frame_lines;
    assign io_vga.err         = r_err;

`ifdef VGA_RX_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    // Statistics saturate instead of wrapping and clear only on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            if (w_fstart && (r_state == LOCKED) && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign io_vga.frame_cnt = r_frame_cnt;
    assign io_vga.err_cnt   = r_err_cnt;
`endif

endmodule
